// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential RV32M multiply/divide unit:
// funct3 operation codes, FSM states and small decode helpers.
package muldiv_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic f3_a_signed(input funct3_e f);
        return f inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    function automatic logic f3_b_signed(input funct3_e f);
        return f inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    endfunction

    function automatic logic f3_is_div(input funct3_e f);
        return f inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
    endfunction

    function automatic logic f3_is_rem(input funct3_e f);
        return f inside {F3_REM, F3_REMU};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
// Signal prefixes are from the unit's point of view (slave modport).
interface muldiv_if;
    logic        i_start;
    logic [2:0]  i_funct3;
    logic [31:0] i_operand_a;
    logic [31:0] i_operand_b;
    logic        i_flush;
    logic        o_stall;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_result;

    modport slave (
        input  i_start, i_funct3, i_operand_a, i_operand_b, i_flush,
        output o_stall, o_busy, o_valid, o_result
    );

    modport master (
        output i_start, i_funct3, i_operand_a, i_operand_b, i_flush,
        input  o_stall, o_busy, o_valid, o_result
    );
endinterface

// File: rtl/muldiv_addsub.sv
// 33-bit adder/subtractor with carry out, shared by the shift-add multiply
// and the restoring-divide trial subtract.
module muldiv_addsub (
    input  logic [32:0] i_a,
    input  logic [32:0] i_b,
    input  logic        i_sub,
    output logic [32:0] o_sum,
    output logic        o_carry
);
    logic [32:0] w_b_inv;
    logic [33:0] w_full;

    // Subtract as a + ~b + 1; carry out high means a >= b (no borrow).
    assign w_b_inv = i_sub ? ~i_b : i_b;
    assign w_full  = {1'b0, i_a} + {1'b0, w_b_inv} + {33'd0, i_sub};
    assign o_sum   = w_full[32:0];
    assign o_carry = w_full[33];
endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide: 32 magnitude iterations in CALC, sign
// correction in FIX, one-cycle result strobe in DONE.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter logic EARLY_DIV0 = 1'b1
) (
    input logic     i_clk,
    input logic     i_rst_n,
    muldiv_if.slave bus
);
    state_e      r_state;
    logic [4:0]  r_cnt;
    funct3_e     r_funct3;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_opb;
    logic [31:0] r_result;
    logic        r_sign_a;
    logic        r_sign_b;
    logic        r_div0;
    logic        r_valid;

    funct3_e     w_funct3;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_b_zero;
    logic        w_early;
    logic        w_is_div;
    logic        w_busy;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_early_res;
    logic [32:0] w_as_a;
    logic [32:0] w_as_b;
    logic [32:0] w_sum;
    logic        w_carry;
    logic [32:0] w_mul_t;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_fix_res;

    assign w_funct3    = funct3_e'(bus.i_funct3);
    assign w_a_neg     = f3_a_signed(w_funct3) & bus.i_operand_a[31];
    assign w_b_neg     = f3_b_signed(w_funct3) & bus.i_operand_b[31];
    assign w_mag_a     = w_a_neg ? (32'd0 - bus.i_operand_a) : bus.i_operand_a;
    assign w_mag_b     = w_b_neg ? (32'd0 - bus.i_operand_b) : bus.i_operand_b;
    assign w_b_zero    = (bus.i_operand_b == 32'd0);
    assign w_early     = EARLY_DIV0 && f3_is_div(w_funct3) && w_b_zero;
    assign w_early_res = f3_is_rem(w_funct3) ? bus.i_operand_a : 32'hFFFF_FFFF;

    // r_lo holds the multiplier (mul) or the dividend/quotient shift register (div);
    // r_hi holds the product high half (mul) or the partial remainder (div).
    assign w_is_div = f3_is_div(r_funct3);
    assign w_as_a   = w_is_div ? {r_hi, r_lo[31]} : {1'b0, r_hi};
    assign w_as_b   = {1'b0, r_opb};

    muldiv_addsub u_addsub (
        .i_a     (w_as_a),
        .i_b     (w_as_b),
        .i_sub   (w_is_div),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    assign w_mul_t = r_lo[0] ? w_sum : {1'b0, r_hi};

    // Divide-by-zero quotient is forced; the remainder naturally equals the dividend.
    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? (64'd0 - w_prod) : w_prod;
    assign w_quo_fix  = r_div0 ? 32'hFFFF_FFFF :
                        ((r_sign_a ^ r_sign_b) ? (32'd0 - r_lo) : r_lo);
    assign w_rem_fix  = r_sign_a ? (32'd0 - r_hi) : r_hi;

    always_comb begin
        w_fix_res = w_quo_fix;
        case (r_funct3)
            F3_MUL:                       w_fix_res = w_prod_fix[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_fix_res = w_prod_fix[63:32];
            F3_REM, F3_REMU:              w_fix_res = w_rem_fix;
            default:                      w_fix_res = w_quo_fix;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 5'd0;
            r_funct3 <= F3_MUL;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_opb    <= 32'd0;
            r_result <= 32'd0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_div0   <= 1'b0;
            r_valid  <= 1'b0;
        end else if (bus.i_flush) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 5'd0;
            r_valid  <= 1'b0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid  <= 1'b0;
                    r_result <= 32'd0;
                    if (bus.i_start) begin
                        r_funct3 <= w_funct3;
                        r_sign_a <= w_a_neg;
                        r_sign_b <= w_b_neg;
                        r_div0   <= f3_is_div(w_funct3) && w_b_zero;
                        r_hi     <= 32'd0;
                        r_lo     <= w_mag_a;
                        r_opb    <= w_mag_b;
                        r_cnt    <= 5'd0;
                        if (w_early) begin
                            r_state  <= ST_DONE;
                            r_valid  <= 1'b1;
                            r_result <= w_early_res;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (w_is_div) begin
                        r_hi <= w_carry ? w_sum[31:0] : {r_hi[30:0], r_lo[31]};
                        r_lo <= {r_lo[30:0], w_carry};
                    end else begin
                        r_hi <= w_mul_t[32:1];
                        r_lo <= {w_mul_t[0], r_lo[31:1]};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_result <= w_fix_res;
                    r_valid  <= 1'b1;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    r_result <= 32'd0;
                    r_valid  <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_busy       = (r_state == ST_CALC) || (r_state == ST_FIX);
    assign bus.o_busy   = w_busy;
    assign bus.o_stall  = i_rst_n && (((r_state == ST_IDLE) && bus.i_start) || w_busy);
    assign bus.o_valid  = r_valid;
    assign bus.o_result = r_result;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: two instances (early divide-by-zero on
// and off) driven in lockstep, directed vectors plus randomized ops vs a model.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    muldiv_if if1 ();
    muldiv_if if0 ();

    muldiv_seq #(.EARLY_DIV0(1'b1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1.slave));
    muldiv_seq #(.EARLY_DIV0(1'b0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0.slave));

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic fl);
        if1.i_start = s; if1.i_funct3 = f; if1.i_operand_a = a; if1.i_operand_b = b; if1.i_flush = fl;
        if0.i_start = s; if0.i_funct3 = f; if0.i_operand_a = a; if0.i_operand_b = b; if0.i_flush = fl;
    endtask

    task automatic check_zero(input string name);
        check({name, "_e1"}, {29'd0, if1.o_valid, if1.o_busy, if1.o_stall, if1.o_result}, 64'd0);
        check({name, "_e0"}, {29'd0, if0.o_valid, if0.o_busy, if0.o_stall, if0.o_result}, 64'd0);
    endtask

    // Reference: RV32M semantics from plain wide arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        int          ia;
        int          ib;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'd0, b});
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name, input int poke_k);
        bit          early;
        int          exp_lat1;
        int          lat1;
        int          lat0;
        logic [31:0] res1;
        logic [31:0] res0;
        bit          ok1;
        bit          ok0;
        logic        eb1;
        logic        eb0;
        early    = f3[2] && (b == 32'd0);
        exp_lat1 = early ? 0 : 33;
        lat1 = -1; lat0 = -1; res1 = 32'd0; res0 = 32'd0;
        @(negedge clk);
        drive(1'b1, f3, a, b, 1'b0);
        #1;
        ok1 = (if1.o_stall === 1'b1);
        ok0 = (if0.o_stall === 1'b1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            eb1 = !early && (k <= 32);
            eb0 = (k <= 32);
            if (if1.o_valid === 1'b1 && lat1 < 0) begin lat1 = k; res1 = if1.o_result; end
            if (if0.o_valid === 1'b1 && lat0 < 0) begin lat0 = k; res0 = if0.o_result; end
            if (if1.o_stall !== eb1 || if1.o_busy !== eb1 || if1.o_valid !== logic'(k == exp_lat1) ||
                (!if1.o_valid && if1.o_result !== 32'd0)) ok1 = 1'b0;
            if (if0.o_stall !== eb0 || if0.o_busy !== eb0 || if0.o_valid !== logic'(k == 33) ||
                (!if0.o_valid && if0.o_result !== 32'd0)) ok0 = 1'b0;
            if (k == poke_k)
                drive(1'b1, ~f3, $urandom, $urandom, 1'b0);
            else if (k == 0 || k == poke_k + 1)
                drive(1'b0, f3 ^ 3'b101, $urandom, $urandom, 1'b0);
        end
        check({name, "_res_e1"}, {32'd0, res1}, {32'd0, exp});
        check({name, "_lat_e1"}, 64'(lat1), 64'(exp_lat1));
        check({name, "_seq_e1"}, {63'd0, ok1}, 64'd1);
        check({name, "_res_e0"}, {32'd0, res0}, {32'd0, exp});
        check({name, "_lat_e0"}, 64'(lat0), 64'd33);
        check({name, "_seq_e0"}, {63'd0, ok0}, 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          nv1;
        int          nv0;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3"};
        vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"};
        vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1"};
        vecs[3]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_-7_2"};
        vecs[4]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_-7_2"};
        vecs[5]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"};
        vecs[6]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf"};
        vecs[7]  = '{3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "divu_5_0"};
        vecs[8]  = '{3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "remu_5_0"};
        vecs[9]  = '{3'b100, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, "div_-5_0"};
        vecs[10] = '{3'b110, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, "rem_-5_0"};
        vecs[11] = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "mulhsu_-1x2"};
        vecs[12] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "mulhsu_min"};
        vecs[13] = '{3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, "remu_100_7"};

        drive(1'b1, 3'b000, 32'd3, 32'd4, 1'b0);
        #2;
        check_zero("reset_state");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);

        for (int i = 0; i < 14; i++)
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, -1);

        run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "start_ignored", 5);

        // Flush at counter value 10.
        @(negedge clk);
        drive(1'b1, 3'b100, 32'd100, 32'd7, 1'b0);
        nv1 = 0; nv0 = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if1.o_valid === 1'b1) nv1++;
            if (if0.o_valid === 1'b1) nv0++;
            if (k == 11) begin
                check("flush_busy_e1", {63'd0, if1.o_busy}, 64'd0);
                check("flush_busy_e0", {63'd0, if0.o_busy}, 64'd0);
            end
            if (k == 10) drive(1'b0, 3'b100, 32'd100, 32'd7, 1'b1);
            else if (k == 0 || k == 11) drive(1'b0, 3'b100, 32'd100, 32'd7, 1'b0);
        end
        check("flush_novalid_e1", 64'(nv1), 64'd0);
        check("flush_novalid_e0", 64'(nv0), 64'd0);

        // Flush beats a simultaneous start.
        @(negedge clk);
        drive(1'b1, 3'b000, 32'd3, 32'd4, 1'b1);
        @(negedge clk);
        check("flush_start_e1", {62'd0, if1.o_busy, if1.o_valid}, 64'd0);
        check("flush_start_e0", {62'd0, if0.o_busy, if0.o_valid}, 64'd0);
        drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);

        // Reset asserted at counter value 20.
        @(negedge clk);
        drive(1'b1, 3'b000, 32'h0001_2345, 32'h0000_6789, 1'b0);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == 0) drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        end
        rst_n = 1'b0;
        drive(1'b1, 3'b000, 32'd3, 32'd4, 1'b0);
        #1;
        check_zero("rst_mid");
        repeat (2) @(negedge clk);
        check_zero("rst_hold");
        rst_n = 1'b1;
        drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        nv1 = 0; nv0 = 0;
        repeat (40) begin
            @(negedge clk);
            if (if1.o_valid === 1'b1) nv1++;
            if (if0.o_valid === 1'b1) nv0++;
        end
        check("rst_novalid_e1", 64'(nv1), 64'd0);
        check("rst_novalid_e0", 64'(nv0), 64'd0);
        run_op(3'b000, 32'd3, 32'd4, 32'h0000_000C, "mul_3x4_after_rst", -1);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            run_op(rf, ra, rb, ref_model(rf, ra, rb), $sformatf("rand%0d_f%0d", i, rf), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter: EARLY_DIV0, default 1, divide-by-zero short-circuit enable (0 = full iteration).
REQ-002 SHALL have port: i_clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: i_rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: i_start  input  1  request new M-extension operation.
REQ-005 SHALL have port: i_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port: i_operand_a  input  32  rs1 value (dividend / multiplicand).
REQ-007 SHALL have port: i_operand_b  input  32  rs2 value (divisor / multiplier).
REQ-008 SHALL have port: i_flush  input  1  abort current operation.
REQ-009 SHALL have port: o_stall  output  1  freeze PC/pipeline while operation outstanding.
REQ-010 SHALL have port: o_busy  output  1  FSM in CALC or FIX.
REQ-011 SHALL have port: o_valid  output  1  one-cycle result strobe.
REQ-012 SHALL have port: o_result  output  32  result, meaningful only while o_valid.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-014 SHALL accept i_start only in IDLE; accept edge latches funct3, operands, operand signs into internal registers.
REQ-015 SHALL ignore i_start in CALC, FIX, DONE; latched operands unaffected by later input changes.
REQ-016 SHALL transition IDLE->CALC on accept; CALC runs exactly 32 cycles (5-bit counter 0..31, wraps to FIX); FIX->DONE; DONE->IDLE.
REQ-017 SHALL give normal latency: accept edge T, o_valid high in cycle T+34 (32 CALC + FIX + DONE).
REQ-018 SHALL in CALC for multiply perform unsigned shift-add on magnitudes (64-bit product), one multiplier bit per cycle.
REQ-019 SHALL in CALC for divide perform restoring division on magnitudes, one quotient bit per cycle, 33-bit trial subtract.
REQ-020 SHALL take magnitudes per signedness: MUL/MULH/DIV/REM both signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned.
REQ-021 SHALL in FIX negate product if signs differ; negate quotient if dividend/divisor signs differ; remainder takes dividend sign.
REQ-022 SHALL select o_result: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits; DIV/DIVU quotient; REM/REMU remainder.
REQ-023 SHALL on divisor zero return quotient 0xFFFFFFFF and remainder = dividend (no exception); with EARLY_DIV0=1 go IDLE->DONE directly, o_valid in cycle T+1.
REQ-024 SHALL on DIV 0x80000000 / 0xFFFFFFFF return quotient 0x80000000, REM 0x00000000.
REQ-025 SHALL drive o_stall = (IDLE and i_start) or CALC or FIX; o_stall low in DONE so pipeline advances with result.
REQ-026 SHALL drive o_busy high exactly in CALC and FIX.
REQ-027 SHALL hold o_result at 0 when o_valid low.
REQ-028 SHALL on i_flush in any state return to IDLE next edge, suppress o_valid, clear counter; flush takes priority over simultaneous i_start.

Reset
REQ-029 SHALL on i_rst_n low, asynchronously: state IDLE, counter 0, all datapath registers 0, o_valid 0, o_busy 0, o_result 0.
REQ-030 SHALL drive o_stall 0 while reset asserted regardless of i_start.
REQ-031 SHALL on reset mid-operation discard operation; no o_valid after release until new accept.

Structure
REQ-032 SHALL place funct3 encoding enum and FSM state enum in shared package muldiv_pkg.
REQ-033 SHALL place 33-bit add/subtract-with-carry datapath in one sub-module muldiv_addsub; FSM and counter stay in muldiv_seq.

Verification
REQ-034 SHALL cover MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> o_result 0xFFFFFFEB, o_valid at T+34, o_stall high T..T+33.
REQ-035 SHALL cover MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-036 SHALL cover DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000.
REQ-037 SHALL cover DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 0x00000005, o_valid at T+1 (EARLY_DIV0=1) and T+34 (EARLY_DIV0=0).
REQ-038 SHALL cover i_start pulsed with new operands during CALC -> ignored, original result delivered; i_flush at counter 10 -> IDLE, no o_valid.
REQ-039 SHALL cover i_rst_n asserted at counter 20 -> outputs 0 immediately; next accepted MUL 3x4 -> 0x0000000C at T+34.
